// File: rtl/hps_smc_initiator.sv
// hps_smc_initiator: Avalon-MM slave acting as initiator on an async SRAM-style static-memory bus.
// Optional WAITN timeout enabled by defining HPS_SMC_INITIATOR_TIMEOUT_EN.
module hps_smc_initiator #(
    parameter int SETUP_CYC   = 1,
    parameter int PULSE_CYC   = 4,
    parameter int HOLD_CYC    = 1,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset_n,
    input  logic [23:0] avs_S1_address,
    input  logic [3:0]  avs_S1_byteenable,
    input  logic        avs_S1_read,
    input  logic        avs_S1_write,
    input  logic [31:0] avs_S1_writedata,
    output logic [31:0] avs_S1_readdata,
    output logic        avs_S1_waitrequest,
    output logic [21:0] coe_M1_ADDR,
    inout  wire  [31:0] coe_M1_DATA,
    output logic [3:0]  coe_M1_CSN,
    output logic [3:0]  coe_M1_BEN,
    output logic        coe_M1_RDN,
    output logic        coe_M1_WRN,
    input  logic        coe_M1_WAITN
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_ACK   = 3'd4;

    // Zero-length phases are clamped to one cycle so every strobe edge is separated.
    localparam int SETUP_EFF   = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
    localparam int PULSE_EFF   = (PULSE_CYC < 1) ? 1 : PULSE_CYC;
    localparam int HOLD_EFF    = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
    localparam int TIMEOUT_EFF = (TIMEOUT_CYC < 1) ? 1 : TIMEOUT_CYC;

    localparam logic [15:0] SETUP_LAST   = 16'(SETUP_EFF - 1);
    localparam logic [15:0] PULSE_LAST   = 16'(PULSE_EFF - 1);
    localparam logic [15:0] HOLD_LAST    = 16'(HOLD_EFF - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_EFF - 1);

    logic [2:0]  state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [23:0] addr_reg, addr_next;
    logic [3:0]  be_reg, be_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        is_read_reg, is_read_next;
    logic [31:0] readdata_reg, readdata_next;

    logic        waitn_meta_reg;
    logic        waitn_s_reg;

    logic [3:0]  csn_reg;
    logic [3:0]  ben_reg;
    logic        rdn_reg;
    logic        wrn_reg;
    logic        data_oe_reg;

    logic        active_next;
    logic [3:0]  cs_sel_next;
    logic        pulse_exit;
    logic        timeout_hit;
    logic [31:0] capture_word;

    // WAITN is asynchronous to MCLK; resets to "not waiting".
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            waitn_meta_reg <= 1'b1;
            waitn_s_reg    <= 1'b1;
        end else begin
            waitn_meta_reg <= coe_M1_WAITN;
            waitn_s_reg    <= waitn_meta_reg;
        end
    end

`ifdef HPS_SMC_INITIATOR_TIMEOUT_EN
    logic [15:0] to_cnt_reg, to_cnt_next;
    logic        timeout_flag_reg, timeout_flag_next;

    assign timeout_hit  = (state_reg == ST_PULSE) && !waitn_s_reg && (to_cnt_reg >= TIMEOUT_LAST);
    assign capture_word = timeout_hit ? 32'hDEADBEEF
                                      : (coe_M1_DATA | {31'd0, timeout_flag_reg});

    always_comb begin
        to_cnt_next       = to_cnt_reg;
        timeout_flag_next = timeout_flag_reg;
        if (state_next != state_reg) begin
            to_cnt_next = 16'd0;
        end else if ((state_reg == ST_PULSE) && !waitn_s_reg && (to_cnt_reg != 16'hFFFF)) begin
            to_cnt_next = to_cnt_reg + 16'd1;
        end
        // The flag survives the timed-out transfer and is consumed by the next good read.
        if (timeout_hit) begin
            timeout_flag_next = 1'b1;
        end else if (pulse_exit && is_read_reg) begin
            timeout_flag_next = 1'b0;
        end
    end

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            to_cnt_reg       <= 16'd0;
            timeout_flag_reg <= 1'b0;
        end else begin
            to_cnt_reg       <= to_cnt_next;
            timeout_flag_reg <= timeout_flag_next;
        end
    end
`else
    wire unused_timeout = ^TIMEOUT_LAST;

    assign timeout_hit  = 1'b0;
    assign capture_word = coe_M1_DATA;
`endif

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        be_next       = be_reg;
        wdata_next    = wdata_reg;
        is_read_next  = is_read_reg;
        readdata_next = readdata_reg;
        pulse_exit    = 1'b0;
        cnt_next      = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                // Read wins a tie; the write stays asserted and is taken next time round.
                if (avs_S1_read || avs_S1_write) begin
                    addr_next    = avs_S1_address;
                    be_next      = avs_S1_byteenable;
                    wdata_next   = avs_S1_writedata;
                    is_read_next = avs_S1_read;
                    state_next   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_reg >= SETUP_LAST) begin
                    state_next = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (((cnt_reg >= PULSE_LAST) && waitn_s_reg) || timeout_hit) begin
                    pulse_exit = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_reg >= HOLD_LAST) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (pulse_exit && is_read_reg) begin
            readdata_next = capture_word;
        end

        if (state_next != state_reg) begin
            cnt_next = 16'd0;
        end else if ((state_reg == ST_SETUP || state_reg == ST_PULSE || state_reg == ST_HOLD)
                     && (cnt_reg != 16'hFFFF)) begin
            cnt_next = cnt_reg + 16'd1;
        end
    end

    assign active_next = (state_next == ST_SETUP) || (state_next == ST_PULSE) ||
                         (state_next == ST_HOLD);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cs_decode
            assign cs_sel_next[gi] = active_next && (addr_next[23:22] == 2'(gi));
        end
    endgenerate

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 16'd0;
            addr_reg     <= 24'd0;
            be_reg       <= 4'd0;
            wdata_reg    <= 32'd0;
            is_read_reg  <= 1'b0;
            readdata_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            be_reg       <= be_next;
            wdata_reg    <= wdata_next;
            is_read_reg  <= is_read_next;
            readdata_reg <= readdata_next;
        end
    end

    // Bus strobes are registered from the next state so they change cleanly with the FSM.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            csn_reg     <= 4'b1111;
            ben_reg     <= 4'b1111;
            rdn_reg     <= 1'b1;
            wrn_reg     <= 1'b1;
            data_oe_reg <= 1'b0;
        end else begin
            csn_reg     <= ~cs_sel_next;
            ben_reg     <= active_next ? ~be_next : 4'b1111;
            rdn_reg     <= !((state_next == ST_PULSE) && is_read_next);
            wrn_reg     <= !((state_next == ST_PULSE) && !is_read_next);
            data_oe_reg <= active_next && !is_read_next;
        end
    end

    assign coe_M1_DATA        = data_oe_reg ? wdata_reg : 32'bz;
    assign coe_M1_ADDR        = addr_reg[21:0];
    assign coe_M1_CSN         = csn_reg;
    assign coe_M1_BEN         = ben_reg;
    assign coe_M1_RDN         = rdn_reg;
    assign coe_M1_WRN         = wrn_reg;
    assign avs_S1_readdata    = readdata_reg;
    assign avs_S1_waitrequest = (state_reg != ST_ACK);

endmodule

// File: tb/tb_hps_smc_initiator.sv
// Self-checking bench for hps_smc_initiator: a behavioural SRAM device on the bus and a
// transfer-level reference model (memory, expected strobe lengths and latencies).
`timescale 1ns/1ps
module tb_hps_smc_initiator;

    localparam int S  = 1;
    localparam int P  = 4;
    localparam int H  = 1;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] address = 24'd0;
    logic [3:0]  byteenable = 4'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [21:0] m_addr;
    wire  [31:0] m_data;
    logic [3:0]  m_csn;
    logic [3:0]  m_ben;
    logic        m_rdn;
    logic        m_wrn;
    logic        m_waitn = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [31:0] dev_mem [64];
    logic [31:0] ref_mem [64];
    logic        drive_en = 1'b0;
    logic        probe_oe = 1'b0;
    logic        dev_bad = 1'b0;
    logic        exp_flag = 1'b0;

    always #5 clk = ~clk;

    hps_smc_initiator #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .TIMEOUT_CYC(TO)) dut (
        .csi_MCLK_clk      (clk),
        .rsi_MRST_reset_n  (rst_n),
        .avs_S1_address    (address),
        .avs_S1_byteenable (byteenable),
        .avs_S1_read       (read),
        .avs_S1_write      (write),
        .avs_S1_writedata  (writedata),
        .avs_S1_readdata   (readdata),
        .avs_S1_waitrequest(waitrequest),
        .coe_M1_ADDR       (m_addr),
        .coe_M1_DATA       (m_data),
        .coe_M1_CSN        (m_csn),
        .coe_M1_BEN        (m_ben),
        .coe_M1_RDN        (m_rdn),
        .coe_M1_WRN        (m_wrn),
        .coe_M1_WAITN      (m_waitn)
    );

    function automatic logic [1:0] csn_bank(input logic [3:0] c);
        case (c)
            4'b1110: return 2'd0;
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Device: drives the addressed word while RDN is low (inverted while it is stalling),
    // zero while selected otherwise; the probe drives zero to reveal any DUT contention.
    logic [5:0]  dev_idx;
    logic [31:0] dev_word;
    assign dev_idx  = {csn_bank(m_csn), m_addr[3:0]};
    assign dev_word = dev_mem[dev_idx];
    assign m_data = ((drive_en && (m_csn != 4'hF)) || probe_oe)
                    ? ((!m_rdn && !probe_oe) ? (dev_bad ? ~dev_word : dev_word) : 32'h0)
                    : 32'bz;

    task automatic start_req(input bit rd, input bit wr, input logic [23:0] a,
                             input logic [3:0] be, input logic [31:0] wd);
        address    = a;
        byteenable = be;
        writedata  = wd;
        read       = rd;
        write      = wr;
    endtask

    // Runs one transfer already requested at the current negedge with the DUT idle.
    task automatic run_xfer(input string name, input bit is_rd, input logic [23:0] a,
                            input logic [3:0] be, input logic [31:0] wd, input int wait_len,
                            input bit exp_to);
        int lat, strobe, pre, post, bad_sig, bad_data, wrong_strobe, wait_left;
        int exp_strobe, exp_lat;
        bit seen, done, prev_wrn, is_strobe;
        logic [3:0]  idle_csn, ack_csn, exp_csn;
        logic [31:0] rd_obs, exp_rd;
        logic [5:0]  idx;
        lat = 0; strobe = 0; pre = 0; post = 0; bad_sig = 0; bad_data = 0;
        wrong_strobe = 0; wait_left = 0;
        seen = 0; done = 0; prev_wrn = 1;
        ack_csn = 4'h0; rd_obs = 32'h0;
        idx      = {a[23:22], a[3:0]};
        exp_csn  = ~(4'b0001 << a[23:22]);
        exp_rd   = exp_to ? 32'hDEADBEEF : (ref_mem[idx] | {31'd0, exp_flag});
        idle_csn = m_csn;
        drive_en = is_rd;
        while (!done && lat < 1000) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (waitrequest == 1'b0) begin
                done    = 1;
                ack_csn = m_csn;
                rd_obs  = readdata;
            end else if (m_csn == 4'hF) begin
                bad_sig++;
            end else begin
                if (m_csn !== exp_csn || m_ben !== ~be || m_addr !== a[21:0]) bad_sig++;
                if (is_rd ? !m_wrn : !m_rdn) wrong_strobe++;
                is_strobe = is_rd ? !m_rdn : !m_wrn;
                if (!is_rd && m_data !== wd) bad_data++;
                if (is_rd && m_rdn && m_data !== 32'h0) bad_data++;
                if (!is_rd && !prev_wrn && m_wrn)
                    dev_mem[dev_idx] = merge_be(dev_mem[dev_idx], m_data, ~m_ben);
                prev_wrn = m_wrn;
                if (is_strobe) begin
                    if (!seen) wait_left = wait_len;
                    seen = 1;
                    strobe++;
                    if (wait_left > 0) begin
                        m_waitn = 1'b0; dev_bad = 1'b1; wait_left--;
                    end else begin
                        m_waitn = 1'b1; dev_bad = 1'b0;
                    end
                end else if (!seen) begin
                    pre++;
                end else begin
                    post++;
                end
            end
        end
        m_waitn = 1'b1;
        dev_bad = 1'b0;

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s no_ack: waited %0d cycles, required ack", name, lat);
        end
        exp_strobe = (wait_len == 0) ? P : ((wait_len + 3 > P) ? wait_len + 3 : P);
        checks++;
        if (exp_to) begin
            if (strobe < TO || strobe > TO + 5) begin
                errors++;
                $display("FAIL %s timeout_strobe: got %0d, required %0d..%0d", name, strobe, TO, TO + 5);
            end
            exp_lat = S + strobe + H + 1;
        end else begin
            if (strobe != exp_strobe) begin
                errors++;
                $display("FAIL %s strobe_len: got %0d, required %0d", name, strobe, exp_strobe);
            end
            exp_lat = S + exp_strobe + H + 1;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
        end
        checks++;
        if (pre != S || post != H) begin
            errors++;
            $display("FAIL %s setup_hold: got %0d/%0d, required %0d/%0d", name, pre, post, S, H);
        end
        checks++;
        if (bad_sig != 0 || wrong_strobe != 0) begin
            errors++;
            $display("FAIL %s bus_ctrl: got %0d bad cs/be/addr, %0d wrong strobe, required 0/0",
                     name, bad_sig, wrong_strobe);
        end
        checks++;
        if (bad_data != 0) begin
            errors++;
            $display("FAIL %s bus_data: got %0d bad cycles, required 0", name, bad_data);
        end
        checks++;
        if (idle_csn !== 4'hF || ack_csn !== 4'hF) begin
            errors++;
            $display("FAIL %s idle_gap: got csn %b/%b, required 1111/1111", name, idle_csn, ack_csn);
        end
        if (is_rd) begin
            checks++;
            if (rd_obs !== exp_rd) begin
                errors++;
                $display("FAIL %s readdata: got %h, required %h", name, rd_obs, exp_rd);
            end
            exp_flag = exp_to;
        end else begin
            ref_mem[idx] = merge_be(ref_mem[idx], wd, be);
            if (exp_to) exp_flag = 1'b1;
        end
        $display("xfer %s %s addr=%h be=%b lat=%0d strobe=%0d rd=%h", name,
                 is_rd ? "RD" : "WR", a, be, lat, strobe, rd_obs);
        @(posedge clk);
        @(negedge clk);
        if (is_rd) read = 1'b0; else write = 1'b0;
        drive_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        probe_oe = 1'b1;
        #1;
        checks++;
        if (m_csn !== 4'hF || m_ben !== 4'hF || m_rdn !== 1'b1 || m_wrn !== 1'b1 ||
            m_addr !== 22'd0 || waitrequest !== 1'b1 || readdata !== 32'd0 || m_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got csn=%b ben=%b rdn=%b wrn=%b addr=%h wr=%b rd=%h data=%h, required 1111 1111 1 1 0 1 0 released",
                     m_csn, m_ben, m_rdn, m_wrn, m_addr, waitrequest, readdata, m_data);
        end
        $display("xfer reset state checked");
        @(negedge clk);
        probe_oe = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        start_req(0, 1, 24'h400010, 4'b0011, 32'hCAFE1234);
        run_xfer("basic_wr", 0, 24'h400010, 4'b0011, 32'hCAFE1234, 0, 0);
        dev_mem[{2'd3, 4'd4}] = 32'h5A5AA5A5;
        ref_mem[{2'd3, 4'd4}] = 32'h5A5AA5A5;
        start_req(1, 0, 24'hC00004, 4'b1111, 32'h11111111);
        run_xfer("basic_rd", 1, 24'hC00004, 4'b1111, 32'h11111111, 0, 0);
        start_req(1, 0, 24'h400010, 4'b1111, 32'h22222222);
        run_xfer("readback", 1, 24'h400010, 4'b1111, 32'h22222222, 0, 0);
    endtask

    task automatic test_waitn();
        start_req(1, 0, 24'h000007, 4'b1111, 32'h33333333);
        run_xfer("waitn10", 1, 24'h000007, 4'b1111, 32'h33333333, 10, 0);
    endtask

    task automatic test_reset_mid_pulse();
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        start_req(0, 1, 24'h800020, 4'b1111, 32'hCAFE1234);
        while (n < 20 && !seen) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (m_wrn == 1'b0) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midreset_strobe: got no WRN fall in %0d cycles, required one", n);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        probe_oe = 1'b1;
        #1;
        checks++;
        if (m_csn !== 4'hF || m_wrn !== 1'b1 || m_rdn !== 1'b1 || m_ben !== 4'hF ||
            waitrequest !== 1'b1 || readdata !== 32'd0 || m_data !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs: got csn=%b wrn=%b rdn=%b ben=%b wr=%b rd=%h data=%h, required 1111 1 1 1111 1 0 released",
                     m_csn, m_wrn, m_rdn, m_ben, waitrequest, readdata, m_data);
        end
        $display("xfer midreset abort after %0d cycles", n);
        @(negedge clk);
        write = 1'b0;
        probe_oe = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        start_req(0, 1, 24'h800021, 4'b0101, 32'h0BADF00D);
        run_xfer("post_reset_wr", 0, 24'h800021, 4'b0101, 32'h0BADF00D, 0, 0);
    endtask

    task automatic test_back_to_back();
        start_req(1, 1, 24'h40000A, 4'b1110, 32'h87654321);
        run_xfer("collide_rd", 1, 24'h40000A, 4'b1110, 32'h87654321, 0, 0);
        run_xfer("collide_wr", 0, 24'h40000A, 4'b1110, 32'h87654321, 0, 0);
        start_req(1, 0, 24'h40000A, 4'b1111, 32'h0);
        run_xfer("b2b_rd0", 1, 24'h40000A, 4'b1111, 32'h0, 0, 0);
        start_req(1, 0, 24'hC00004, 4'b1111, 32'h0);
        run_xfer("b2b_rd1", 1, 24'hC00004, 4'b1111, 32'h0, 0, 0);
    endtask

    task automatic test_random();
        logic [23:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          rd;
        int          wl;
        for (int i = 0; i < 24; i++) begin
            a  = {2'($urandom_range(0, 3)), 18'd0, 4'($urandom_range(0, 15))};
            be = 4'($urandom_range(1, 15));
            wd = $urandom;
            rd = 1'($urandom_range(0, 1));
            wl = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 7);
            start_req(rd, !rd, a, be, wd);
            run_xfer("random", rd, a, be, wd, wl, 0);
        end
    endtask

`ifdef HPS_SMC_INITIATOR_TIMEOUT_EN
    task automatic test_timeout();
        dev_mem[{2'd2, 4'd6}] = 32'h12345670;
        ref_mem[{2'd2, 4'd6}] = 32'h12345670;
        start_req(1, 0, 24'h800006, 4'b1111, 32'h0);
        run_xfer("timeout_rd", 1, 24'h800006, 4'b1111, 32'h0, 5000, 1);
        start_req(1, 0, 24'h800006, 4'b1111, 32'h0);
        run_xfer("flag_rd", 1, 24'h800006, 4'b1111, 32'h0, 0, 0);
        start_req(1, 0, 24'h800006, 4'b1111, 32'h0);
        run_xfer("flag_clear_rd", 1, 24'h800006, 4'b1111, 32'h0, 0, 0);
    endtask
`endif

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            dev_mem[i] = v;
            ref_mem[i] = v;
        end
        test_reset();
        test_basic();
        test_waitn();
        test_reset_mid_pulse();
        test_back_to_back();
        test_random();
`ifdef HPS_SMC_INITIATOR_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2 ms, required completion");
        $fatal(1, "watchdog");
    end

endmodule
